// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC fetch/decode stage.
// Contents: opcode constants, instruction field bit positions, fetch FSM state
// enum and the register-write decode helper.
package nrisc_pkg;

   // Opcodes
   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_ALU_MIN = 4'h1;
   localparam logic [3:0] OP_ALU_MAX = 4'h9;
   localparam logic [3:0] OP_LI      = 4'hA;
   localparam logic [3:0] OP_ST      = 4'hB;
   localparam logic [3:0] OP_BEQ     = 4'hC;
   localparam logic [3:0] OP_JMP     = 4'hD;
   localparam logic [3:0] OP_RES     = 4'hE;
   localparam logic [3:0] OP_HALT    = 4'hF;

   // Instruction field bit positions
   localparam int unsigned OPCODE_MSB = 15;
   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned RD_MSB     = 11;
   localparam int unsigned RD_LSB     = 9;
   localparam int unsigned RS1_MSB    = 8;
   localparam int unsigned RS1_LSB    = 6;
   localparam int unsigned RS2_MSB    = 5;
   localparam int unsigned RS2_LSB    = 3;
   localparam int unsigned IMM_MSB    = 7;
   localparam int unsigned IMM_LSB    = 0;

   // Fetch/decode FSM states
   typedef enum logic [1:0] {
      BUSCA_ALTO,
      BUSCA_BAIXO,
      EMITE,
      PARADO
   } estado_t;

   // Only ALU ops and LI write the register bank; reserved 4'hE behaves as NOP.
   function automatic logic escreve_reg(input logic [3:0] op);
      logic res;
      case (op)
         OP_NOP, OP_ST, OP_BEQ, OP_JMP, OP_RES, OP_HALT: res = 1'b0;
         default: res = ((op >= OP_ALU_MIN) && (op <= OP_ALU_MAX)) || (op == OP_LI);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/decodificador.sv
// Combinational instruction decoder.
// Ports: palavra_i (16-bit instruction) -> opcode_o, reg_escrito_o, reg_lido1_o,
// reg_lido2_o, imediato_o, sobrescrever_o (register write enable), eh_halt_o.
module decodificador
   import nrisc_pkg::*;
(
   input  logic [15:0] palavra_i,
   output logic [3:0]  opcode_o,
   output logic [2:0]  reg_escrito_o,
   output logic [2:0]  reg_lido1_o,
   output logic [2:0]  reg_lido2_o,
   output logic [7:0]  imediato_o,
   output logic        sobrescrever_o,
   output logic        eh_halt_o
);

   always_comb begin
      opcode_o       = palavra_i[OPCODE_MSB:OPCODE_LSB];
      reg_escrito_o  = palavra_i[RD_MSB:RD_LSB];
      reg_lido1_o    = palavra_i[RS1_MSB:RS1_LSB];
      reg_lido2_o    = palavra_i[RS2_MSB:RS2_LSB];
      // Immediate overlaps the register fields; downstream picks what it needs.
      imediato_o     = palavra_i[IMM_MSB:IMM_LSB];
      sobrescrever_o = escreve_reg(palavra_i[OPCODE_MSB:OPCODE_LSB]);
      eh_halt_o      = (palavra_i[OPCODE_MSB:OPCODE_LSB] == OP_HALT);
   end

endmodule

// File: rtl/busca_decodifica.sv
// Fetch/decode stage feeding the register bank and execute stage.
// Fetches 16-bit instructions as two bytes (high byte first) over a req/ack
// byte interface, decodes them and issues them with a valid/ready handshake.
// Ports:
//   Clock, Reset (synchronous, active-high)
//   MemReq/MemEndereco/MemAck/MemDado : instruction-memory byte interface
//   Desvio/AlvoDesvio                 : branch redirect from execute
//   EmiteValido/EmitePronto           : issue handshake
//   Opcode, RegEscrito, RegLido1, RegLido2, Imediato, Sobrescrever : decoded fields
//   PC, Halt                          : current fetch PC, halted flag
module busca_decodifica
   import nrisc_pkg::*;
#(
   parameter int unsigned            LARGURA_END = 8,
   parameter logic [LARGURA_END-1:0] PC_INICIAL  = '0
) (
   input  logic                   Clock,
   input  logic                   Reset,
   output logic                   MemReq,
   output logic [LARGURA_END-1:0] MemEndereco,
   input  logic                   MemAck,
   input  logic [7:0]             MemDado,
   input  logic                   Desvio,
   input  logic [LARGURA_END-1:0] AlvoDesvio,
   output logic                   EmiteValido,
   input  logic                   EmitePronto,
   output logic [3:0]             Opcode,
   output logic [2:0]             RegEscrito,
   output logic [2:0]             RegLido1,
   output logic [2:0]             RegLido2,
   output logic [7:0]             Imediato,
   output logic                   Sobrescrever,
   output logic [LARGURA_END-1:0] PC,
   output logic                   Halt
);

   localparam logic [LARGURA_END-1:0] PC_PASSO = 1;

   estado_t    estado;
   logic [7:0] ir_alto;
   logic       halt_pendente;

   logic [3:0] dec_opcode;
   logic [2:0] dec_reg_escrito;
   logic [2:0] dec_reg_lido1;
   logic [2:0] dec_reg_lido2;
   logic [7:0] dec_imediato;
   logic       dec_sobrescrever;
   logic       dec_eh_halt;

   // Low byte is decoded straight off the bus so fields register on its ack.
   decodificador u_decodificador (
      .palavra_i      ({ir_alto, MemDado}),
      .opcode_o       (dec_opcode),
      .reg_escrito_o  (dec_reg_escrito),
      .reg_lido1_o    (dec_reg_lido1),
      .reg_lido2_o    (dec_reg_lido2),
      .imediato_o     (dec_imediato),
      .sobrescrever_o (dec_sobrescrever),
      .eh_halt_o      (dec_eh_halt)
   );

   assign MemReq      = (estado == BUSCA_ALTO) || (estado == BUSCA_BAIXO);
   assign MemEndereco = PC;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado        <= BUSCA_ALTO;
         PC            <= PC_INICIAL;
         ir_alto       <= '0;
         halt_pendente <= 1'b0;
         EmiteValido   <= 1'b0;
         Halt          <= 1'b0;
         Opcode        <= '0;
         RegEscrito    <= '0;
         RegLido1      <= '0;
         RegLido2      <= '0;
         Imediato      <= '0;
         Sobrescrever  <= 1'b0;
      end else if (Desvio && (estado != PARADO)) begin
         // Redirect wins over any ack or issue in this cycle.
         estado        <= BUSCA_ALTO;
         PC            <= AlvoDesvio;
         EmiteValido   <= 1'b0;
         halt_pendente <= 1'b0;
      end else begin
         unique case (estado)
            BUSCA_ALTO: begin
               if (MemAck) begin
                  ir_alto <= MemDado;
                  PC      <= PC + PC_PASSO;
                  estado  <= BUSCA_BAIXO;
               end
            end
            BUSCA_BAIXO: begin
               if (MemAck) begin
                  PC            <= PC + PC_PASSO;
                  Opcode        <= dec_opcode;
                  RegEscrito    <= dec_reg_escrito;
                  RegLido1      <= dec_reg_lido1;
                  RegLido2      <= dec_reg_lido2;
                  Imediato      <= dec_imediato;
                  Sobrescrever  <= dec_sobrescrever;
                  halt_pendente <= dec_eh_halt;
                  EmiteValido   <= 1'b1;
                  estado        <= EMITE;
               end
            end
            EMITE: begin
               if (EmitePronto) begin
                  EmiteValido <= 1'b0;
                  if (halt_pendente) begin
                     Halt   <= 1'b1;
                     estado <= PARADO;
                  end else begin
                     estado <= BUSCA_ALTO;
                  end
               end
            end
            PARADO: begin
               // Only Reset leaves this state.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_busca_decodifica.sv
module tb_busca_decodifica;

   logic       Clock;
   logic       Reset;
   logic       MemReq;
   logic [7:0] MemEndereco;
   logic       MemAck;
   logic [7:0] MemDado;
   logic       Desvio;
   logic [7:0] AlvoDesvio;
   logic       EmiteValido;
   logic       EmitePronto;
   logic [3:0] Opcode;
   logic [2:0] RegEscrito;
   logic [2:0] RegLido1;
   logic [2:0] RegLido2;
   logic [7:0] Imediato;
   logic       Sobrescrever;
   logic [7:0] PC;
   logic       Halt;

   logic [7:0] mem [256];
   logic       ack_en;
   int         checks;
   int         errors;

   assign MemDado = mem[MemEndereco];
   assign MemAck  = ack_en;

   busca_decodifica #(
      .LARGURA_END (8),
      .PC_INICIAL  (8'h00)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .MemReq       (MemReq),
      .MemEndereco  (MemEndereco),
      .MemAck       (MemAck),
      .MemDado      (MemDado),
      .Desvio       (Desvio),
      .AlvoDesvio   (AlvoDesvio),
      .EmiteValido  (EmiteValido),
      .EmitePronto  (EmitePronto),
      .Opcode       (Opcode),
      .RegEscrito   (RegEscrito),
      .RegLido1     (RegLido1),
      .RegLido2     (RegLido2),
      .Imediato     (Imediato),
      .Sobrescrever (Sobrescrever),
      .PC           (PC),
      .Halt         (Halt)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h12;
      mem[1] = 8'h9A;
      mem[2] = 8'h34;
      mem[3] = 8'h56;
      mem[8'hFF] = 8'hA0;

      Reset       = 1'b1;
      ack_en      = 1'b1;   // ack during reset must be ignored
      Desvio      = 1'b0;
      AlvoDesvio  = 8'h00;
      EmitePronto = 1'b0;
      tick();
      tick();
      chk("rst_pc", 16'(PC), 16'h00);
      chk("rst_valid", 16'(EmiteValido), 16'h0);
      chk("rst_halt", 16'(Halt), 16'h0);
      chk("rst_opcode", 16'(Opcode), 16'h0);
      chk("rst_sobre", 16'(Sobrescrever), 16'h0);
      chk("rst_memreq", 16'(MemReq), 16'h1);

      // Word 0x129A with zero-wait memory
      Reset = 1'b0;
      tick();
      chk("f1_pc", 16'(PC), 16'h01);
      chk("f1_valid", 16'(EmiteValido), 16'h0);
      tick();
      chk("f2_valid", 16'(EmiteValido), 16'h1);
      chk("f2_opcode", 16'(Opcode), 16'h1);
      chk("f2_rd", 16'(RegEscrito), 16'h1);
      chk("f2_rs1", 16'(RegLido1), 16'h2);
      chk("f2_rs2", 16'(RegLido2), 16'h3);
      chk("f2_imm", 16'(Imediato), 16'h9A);
      chk("f2_sobre", 16'(Sobrescrever), 16'h1);
      chk("f2_pc", 16'(PC), 16'h02);
      chk("f2_memreq", 16'(MemReq), 16'h0);

      // Downstream stalls for 4 cycles
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_valid", 16'(EmiteValido), 16'h1);
         chk("stall_opcode", 16'(Opcode), 16'h1);
         chk("stall_imm", 16'(Imediato), 16'h9A);
         chk("stall_memreq", 16'(MemReq), 16'h0);
         chk("stall_pc", 16'(PC), 16'h02);
      end
      EmitePronto = 1'b1;
      tick();
      EmitePronto = 1'b0;
      chk("acc_valid", 16'(EmiteValido), 16'h0);
      chk("acc_memreq", 16'(MemReq), 16'h1);
      chk("acc_addr", 16'(MemEndereco), 16'h02);

      // Desvio collides with the low-byte ack
      tick();
      chk("hi_pc", 16'(PC), 16'h03);
      Desvio     = 1'b1;
      AlvoDesvio = 8'h40;
      tick();
      Desvio = 1'b0;
      chk("br_valid", 16'(EmiteValido), 16'h0);
      chk("br_addr", 16'(MemEndereco), 16'h40);
      chk("br_memreq", 16'(MemReq), 16'h1);

      // Redirect to 0xFF, LI word straddling the wrap
      mem[0]     = 8'h55;
      Desvio     = 1'b1;
      AlvoDesvio = 8'hFF;
      tick();
      Desvio = 1'b0;
      chk("wr_pc0", 16'(PC), 16'hFF);
      tick();
      chk("wr_pc1", 16'(PC), 16'h00);
      tick();
      chk("wr_valid", 16'(EmiteValido), 16'h1);
      chk("wr_opcode", 16'(Opcode), 16'hA);
      chk("wr_imm", 16'(Imediato), 16'h55);
      chk("wr_sobre", 16'(Sobrescrever), 16'h1);
      chk("wr_rd", 16'(RegEscrito), 16'h0);
      chk("wr_rs1", 16'(RegLido1), 16'h1);
      chk("wr_pc2", 16'(PC), 16'h01);
      EmitePronto = 1'b1;
      tick();
      EmitePronto = 1'b0;
      chk("wr_acc_valid", 16'(EmiteValido), 16'h0);

      // HALT squashed by a Desvio in its issue cycle
      mem[1] = 8'hF0;
      mem[2] = 8'h00;
      tick();
      tick();
      chk("sq_opcode", 16'(Opcode), 16'hF);
      chk("sq_sobre", 16'(Sobrescrever), 16'h0);
      chk("sq_valid0", 16'(EmiteValido), 16'h1);
      Desvio      = 1'b1;
      AlvoDesvio  = 8'h10;
      EmitePronto = 1'b1;
      tick();
      Desvio      = 1'b0;
      EmitePronto = 1'b0;
      chk("sq_valid", 16'(EmiteValido), 16'h0);
      chk("sq_halt", 16'(Halt), 16'h0);
      chk("sq_pc", 16'(PC), 16'h10);
      chk("sq_memreq", 16'(MemReq), 16'h1);

      // Real HALT
      mem[8'h10] = 8'hF0;
      mem[8'h11] = 8'h00;
      tick();
      tick();
      chk("h_valid", 16'(EmiteValido), 16'h1);
      EmitePronto = 1'b1;
      tick();
      EmitePronto = 1'b0;
      chk("h_halt", 16'(Halt), 16'h1);
      chk("h_valid0", 16'(EmiteValido), 16'h0);
      Desvio     = 1'b1;
      AlvoDesvio = 8'h40;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("h_stay_halt", 16'(Halt), 16'h1);
         chk("h_stay_memreq", 16'(MemReq), 16'h0);
         chk("h_stay_pc", 16'(PC), 16'h12);
         chk("h_stay_valid", 16'(EmiteValido), 16'h0);
      end
      Desvio = 1'b0;
      Reset  = 1'b1;
      tick();
      Reset = 1'b0;
      chk("hr_pc", 16'(PC), 16'h00);
      chk("hr_halt", 16'(Halt), 16'h0);
      chk("hr_memreq", 16'(MemReq), 16'h1);

      // Reset in BUSCA_BAIXO with an ack pending
      tick();
      chk("mr_pc1", 16'(PC), 16'h01);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("mr_pc", 16'(PC), 16'h00);
      chk("mr_valid", 16'(EmiteValido), 16'h0);
      chk("mr_memreq", 16'(MemReq), 16'h1);
      tick();
      chk("mr_after_pc", 16'(PC), 16'h01);
      chk("mr_after_valid", 16'(EmiteValido), 16'h0);
      tick();
      chk("mr_issue_valid", 16'(EmiteValido), 16'h1);
      chk("mr_issue_imm", 16'(Imediato), 16'hF0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/busca_decodifica.md
Name: busca_decodifica

Overview:
- Fetch/decode stage directly upstream of the 8-entry register bank (registadores).
- Holds the PC and fetches 16-bit instructions as two bytes from an 8-bit instruction memory over a req/ack handshake.
- Decodes each instruction into register-bank read/write addresses, the write-enable (Sobrescrever), an immediate and the opcode.
- Presents the decoded instruction to the register bank and execute stage with a valid/ready handshake, and owns Halt generation and branch redirection.

Parameters:
- LARGURA_END, 8, PC / instruction-memory address width.
- PC_INICIAL, 8'h00, PC value loaded on reset.

Ports:
- Clock  input  1  single clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- MemReq  output  1  instruction-memory byte request.
- MemEndereco  output  LARGURA_END  byte address; equals PC.
- MemAck  input  1  byte valid on MemDado this cycle.
- MemDado  input  8  instruction byte.
- Desvio  input  1  taken branch/jump from execute; redirect PC.
- AlvoDesvio  input  LARGURA_END  branch target.
- EmiteValido  output  1  decoded instruction valid.
- EmitePronto  input  1  downstream accepts the instruction.
- Opcode  output  4  instruction bits [15:12].
- RegEscrito  output  3  bits [11:9].
- RegLido1  output  3  bits [8:6].
- RegLido2  output  3  bits [5:3].
- Imediato  output  8  bits [7:0].
- Sobrescrever  output  1  register write enable.
- PC  output  LARGURA_END  current fetch PC.
- Halt  output  1  processor halted.

Behaviour:
- Reset (synchronous, active-high; also mid-operation): PC=PC_INICIAL, state=BUSCA_ALTO, Halt=0, EmiteValido=0, decoded outputs=0. MemReq is a combinational function of state, so it is 1 in the first cycle after reset. A MemAck in the reset cycle is ignored.
- FSM states: BUSCA_ALTO, BUSCA_BAIXO, EMITE, PARADO.
- BUSCA_ALTO:
  - MemReq=1, MemEndereco=PC, held stable until MemAck.
  - On MemAck: IR[15:8]<=MemDado, PC<=PC+1, go to BUSCA_BAIXO.
- BUSCA_BAIXO: same handshake. On MemAck: IR[7:0]<=MemDado, PC<=PC+1; the decoded fields are registered; EmiteValido<=1; go to EMITE.
- EMITE:
  - MemReq=0; outputs stay stable while EmiteValido=1 and EmitePronto=0.
  - On EmitePronto: EmiteValido<=0.
  - If Opcode=HALT (4'hF), go to PARADO and set Halt<=1; otherwise go to BUSCA_ALTO.
- PARADO: MemReq=0, EmiteValido=0, Halt=1. The only exit is Reset; Desvio is ignored.
- Zero-wait memory (MemAck in the same cycle as MemReq) gives 3 cycles per instruction.
- The PC is LARGURA_END-bit unsigned and wraps 8'hFF+1 -> 8'h00. A high byte at 8'hFF with the low byte at 8'h00 is legal.
- Decode:
  - Opcodes 4'h1..4'h9 (ALU) and 4'hA (LI): Sobrescrever=1.
  - 4'h0 NOP, 4'hB ST, 4'hC BEQ, 4'hD JMP, 4'hE (reserved, treated as NOP) and 4'hF HALT: Sobrescrever=0.
  - Imediato is always IR[7:0]; downstream decides its use.
- Desvio (any state except PARADO) has priority over everything except Reset:
  - PC<=AlvoDesvio, EmiteValido<=0, any partial IR is discarded, go to BUSCA_ALTO.
  - A MemAck in the same cycle is discarded.
  - In EMITE, a transfer in the Desvio cycle is void even if EmitePronto=1. A squashed HALT does not enter PARADO.
- MemAck while MemReq=0 is ignored. EmitePronto while EmiteValido=0 is ignored.

Decomposition:
- Shared package nrisc_pkg holds:
  - opcode constants (OP_NOP, OP_LI, OP_ST, OP_BEQ, OP_JMP, OP_HALT, ALU range);
  - field bit positions;
  - the state enum (BUSCA_ALTO, BUSCA_BAIXO, EMITE, PARADO).
- One combinational sub-module, decodificador: 16-bit word in, producing Opcode, RegEscrito, RegLido1, RegLido2, Imediato, Sobrescrever and eh_halt. The FSM, PC and output registers stay in busca_decodifica.

Test Plan:
- Reset, memory bytes 8'h12, 8'h9A at addresses 0 and 1, zero-wait ack, EmitePronto=1 -> cycle 3: EmiteValido=1, Opcode=1, RegEscrito=1, RegLido1=2, RegLido2=3, Imediato=8'h9A, Sobrescrever=1, PC=2.
- EmitePronto held 0 for 4 cycles -> outputs frozen, MemReq=0; accepted on cycle 5, then MemEndereco=2.
- Desvio=1, AlvoDesvio=8'h40 in the same cycle as MemAck in BUSCA_BAIXO -> byte discarded, EmiteValido=0, next MemEndereco=8'h40.
- Start PC=8'hFF, word 8'hA0, 8'h55 -> issued as LI with Imediato=8'h55, Sobrescrever=1; PC wraps to 8'h01.
- Word 8'hF0, 8'h00 accepted -> Halt=1, MemReq=0 indefinitely; a Desvio is ignored; Reset pulse restores PC=0, Halt=0.
- Reset asserted mid-BUSCA_BAIXO with MemAck=1 -> next cycle PC=0, state BUSCA_ALTO, EmiteValido=0.
